// File: rtl/dvp_pkg.sv
// Shared types, timing defaults and byte-format helpers for the DVP transmitter.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } dvp_state_e;

  localparam int unsigned DEF_COLS        = 320;
  localparam int unsigned DEF_ROWS        = 240;
  localparam int unsigned DEF_HBLANK      = 144;
  localparam int unsigned DEF_VSYNC_LINES = 3;
  localparam int unsigned DEF_VBP_LINES   = 17;
  localparam int unsigned DEF_VFP_LINES   = 10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // RGB444 xR/GB byte order: red nibble first, then green/blue.
  function automatic logic [7:0] hi_byte(input logic [3:0] r);
    return {4'b0000, r};
  endfunction

  function automatic logic [7:0] lo_byte(input logic [3:0] g, input logic [3:0] b);
    return {g, b};
  endfunction

endpackage

// File: rtl/dvp_tx_if.sv
// Pixel valid/ready stream feeding the DVP transmitter.
interface dvp_tx_if;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/dvp_pix_hold.sv
// One-entry pixel holding register: accepts when empty, emptied by a consume strobe.
module dvp_pix_hold (
  input  logic        clk,
  input  logic        rst,
  dvp_tx_if.slave     pix,
  input  logic        consume,
  output logic        hold_valid,
  output logic [11:0] hold_data
);

  logic load;

  assign pix.pix_ready = !hold_valid;
  assign load          = pix.pix_valid && !hold_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (load) begin
      hold_valid <= 1'b1;
      hold_data  <= pix.pix_data;
    end else if (consume) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dvp_tx.sv
// OV7670-style DVP transmitter: frame/line timing FSM driving PCLK, VSYNC, HREF and RGB444 bytes.
module dvp_tx
  import dvp_pkg::*;
#(
  parameter int unsigned COLS        = DEF_COLS,
  parameter int unsigned ROWS        = DEF_ROWS,
  parameter int unsigned HBLANK      = DEF_HBLANK,
  parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int unsigned VBP_LINES   = DEF_VBP_LINES,
  parameter int unsigned VFP_LINES   = DEF_VFP_LINES
) (
  input  logic       clkMain,
  input  logic       rstMain,
  input  logic       enable,
  dvp_tx_if.slave    pix,
  output logic       dvp_pclk,
  output logic       dvp_vsync,
  output logic       dvp_href,
  output logic [7:0] dvp_data,
  output logic       frame_done,
  output logic       underflow,
  output logic       busy
);

  localparam int unsigned ACT_SLOTS = 2 * COLS;
  localparam int unsigned SLOTS     = ACT_SLOTS + HBLANK;
  localparam int unsigned MAX_LINES = max_u(max_u(VSYNC_LINES, VBP_LINES), max_u(ROWS, VFP_LINES));
  localparam int unsigned BW        = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned LW        = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  dvp_state_e  state, state_nx;
  logic        phase;
  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] line_cnt;
  logic [LW-1:0] stage_last;
  logic        byte_last, line_last, slot_end, stage_end;
  logic        active_slot, consume;
  logic        hold_valid;
  logic [11:0] hold_data;
  logic [11:0] pix_lat;

  dvp_pix_hold u_hold (
    .clk        (clkMain),
    .rst        (rstMain),
    .pix        (pix),
    .consume    (consume),
    .hold_valid (hold_valid),
    .hold_data  (hold_data)
  );

  always_comb begin
    stage_last = '0;
    case (state)
      ST_VSYNC:  stage_last = LW'(VSYNC_LINES - 1);
      ST_VBP:    stage_last = LW'(VBP_LINES - 1);
      ST_ACTIVE: stage_last = LW'(ROWS - 1);
      ST_VFP:    stage_last = LW'(VFP_LINES - 1);
      default:   stage_last = '0;
    endcase
  end

  assign byte_last   = (byte_cnt == BW'(SLOTS - 1));
  assign line_last   = (line_cnt == stage_last);
  assign slot_end    = phase && byte_last;
  assign stage_end   = slot_end && line_last;
  assign active_slot = (state == ST_ACTIVE) && (32'(byte_cnt) < ACT_SLOTS);
  assign consume     = active_slot && !byte_cnt[0] && !phase;

  always_ff @(posedge clkMain) begin
    if (rstMain) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (enable)    state_nx = ST_VSYNC;
      ST_VSYNC:  if (stage_end) state_nx = ST_VBP;
      ST_VBP:    if (stage_end) state_nx = ST_ACTIVE;
      ST_ACTIVE: if (stage_end) state_nx = ST_VFP;
      ST_VFP:    if (stage_end) state_nx = enable ? ST_VSYNC : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkMain) begin
    if (rstMain || state == ST_IDLE) begin
      phase    <= 1'b0;
      byte_cnt <= '0;
      line_cnt <= '0;
    end else begin
      phase <= !phase;
      if (phase) begin
        byte_cnt <= byte_last ? '0 : byte_cnt + BW'(1);
        if (byte_last) line_cnt <= line_last ? '0 : line_cnt + LW'(1);
      end
    end
  end

  always_ff @(posedge clkMain) begin
    if (rstMain) begin
      pix_lat   <= '0;
      underflow <= 1'b0;
    end else if (consume) begin
      pix_lat <= hold_valid ? hold_data : '0;
      if (!hold_valid) underflow <= 1'b1;
    end
  end

  // Even byte comes straight from the holding register on phase 0 so a pixel
  // accepted one cycle earlier still makes its slot; pix_lat covers the rest.
  always_comb begin
    dvp_data = '0;
    if (active_slot) begin
      if (byte_cnt[0])     dvp_data = lo_byte(pix_lat[7:4], pix_lat[3:0]);
      else if (phase)      dvp_data = hi_byte(pix_lat[11:8]);
      else if (hold_valid) dvp_data = hi_byte(hold_data[11:8]);
    end
  end

  assign dvp_pclk   = phase;
  assign dvp_vsync  = (state == ST_VSYNC);
  assign dvp_href   = active_slot;
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_VFP) && stage_end;

endmodule

// File: tb/tb_dvp_tx.sv
// Randomized self-checking bench for dvp_tx against a frame-position reference model.
module tb_dvp_tx;

  localparam int unsigned COLS  = 4;
  localparam int unsigned ROWS  = 2;
  localparam int unsigned HBL   = 2;
  localparam int unsigned VSL   = 1;
  localparam int unsigned VBPL  = 1;
  localparam int unsigned VFPL  = 1;
  localparam int unsigned L     = 2 * COLS + HBL;
  localparam int unsigned LINES = VSL + VBPL + ROWS + VFPL;
  localparam int unsigned FRAME = 2 * L * LINES;
  localparam int unsigned FIRST = VSL + VBPL;
  localparam int unsigned LIMIT = 4 * FRAME;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       dvp_pclk, dvp_vsync, dvp_href, frame_done, underflow, busy;
  logic [7:0] dvp_data;

  dvp_tx_if pix ();

  always #5 clk = ~clk;

  dvp_tx #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .HBLANK      (HBL),
    .VSYNC_LINES (VSL),
    .VBP_LINES   (VBPL),
    .VFP_LINES   (VFPL)
  ) dut (
    .clkMain    (clk),
    .rstMain    (rst),
    .enable     (enable),
    .pix        (pix),
    .dvp_pclk   (dvp_pclk),
    .dvp_vsync  (dvp_vsync),
    .dvp_href   (dvp_href),
    .dvp_data   (dvp_data),
    .frame_done (frame_done),
    .underflow  (underflow),
    .busy       (busy)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: position within the frame plus a pixel FIFO of depth one.
  bit          m_busy = 1'b0;
  int unsigned m_t = 0;
  logic [11:0] m_q[$];
  logic [11:0] m_slot = '0;
  bit          m_uflow = 1'b0;

  logic [11:0] dir_pix [3] = '{12'hABC, 12'h123, 12'h456};
  logic [11:0] pend;
  int unsigned dir_idx;
  int unsigned fcyc = 0, vs_hi = 0, href_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic en, input int vmode);
    int unsigned slot, ph, line, b;
    bit          in_act, even0, exp_ready, v;
    logic [7:0]  exp_data;
    logic [11:0] popped;
    @(posedge clk);
    #1;
    slot   = m_t / 2;
    ph     = m_t % 2;
    line   = slot / L;
    b      = slot % L;
    in_act = m_busy && line >= FIRST && line < FIRST + ROWS && b < 2 * COLS;
    even0  = in_act && (b % 2 == 0) && ph == 0;
    if (even0) m_slot = (m_q.size() != 0) ? m_q[0] : 12'h000;
    exp_data  = !in_act ? 8'h00 : (b % 2 == 0) ? {4'h0, m_slot[11:8]} : m_slot[7:0];
    exp_ready = (m_q.size() == 0);

    check("pclk",       dvp_pclk,      m_busy && ph == 1);
    check("vsync",      dvp_vsync,     m_busy && line < VSL);
    check("href",       dvp_href,      in_act);
    check("data",       dvp_data,      exp_data);
    check("frame_done", frame_done,    m_busy && m_t == FRAME - 1);
    check("underflow",  underflow,     m_uflow);
    check("busy",       busy,          m_busy);
    check("pix_ready",  pix.pix_ready, exp_ready);

    if (rst) begin
      fcyc = 0; vs_hi = 0; href_run = 0;
    end else begin
      if (dvp_href) href_run++;
      else if (href_run != 0) begin
        check("href_len", href_run, 2 * 2 * COLS);
        href_run = 0;
      end
      if (busy) fcyc++;
      if (dvp_vsync) vs_hi++;
      if (frame_done) begin
        check("frame_len", fcyc, FRAME);
        check("vsync_len", vs_hi, 2 * L * VSL);
        fcyc = 0; vs_hi = 0;
      end
      if (!busy) begin
        fcyc = 0; vs_hi = 0;
      end
    end

    case (vmode)
      0:       v = 1'b1;
      1:       v = !(m_busy && m_t >= 2 * L * FIRST && m_t < 2 * L * FIRST + 4);
      2:       v = ($urandom_range(0, 9) < 8);
      default: v = 1'b0;
    endcase
    rst           = r;
    enable        = en;
    pix.pix_valid = v;
    pix.pix_data  = pend;

    if (r) begin
      m_busy = 1'b0; m_t = 0; m_q.delete(); m_slot = '0; m_uflow = 1'b0;
    end else begin
      if (even0) begin
        if (m_q.size() != 0) popped = m_q.pop_front();
        else m_uflow = 1'b1;
      end
      if (v && exp_ready) begin
        m_q.push_back(pend);
        if (dir_idx < 3) begin
          pend = dir_pix[dir_idx];
          dir_idx++;
        end else begin
          pend = 12'($urandom);
        end
      end
      if (!m_busy) begin
        if (en) begin m_busy = 1'b1; m_t = 0; end
      end else if (m_t == FRAME - 1) begin
        if (en) m_t = 0;
        else m_busy = 1'b0;
      end else begin
        m_t++;
      end
    end
  endtask

  initial begin
    int unsigned n;
    pix.pix_valid = 1'b0;
    pix.pix_data  = '0;
    pend    = dir_pix[0];
    dir_idx = 1;

    repeat (3) step(1'b1, 1'b0, 3);
    repeat (2 * FRAME + 10) step(1'b0, 1'b1, 0);

    repeat (2) step(1'b1, 1'b0, 3);
    repeat (FRAME + 20) step(1'b0, 1'b1, 1);

    repeat (2) step(1'b1, 1'b0, 3);
    repeat (3 * FRAME) step(1'b0, 1'b1, 2);

    // drop enable in the middle of an active line
    n = 0;
    while (!(m_busy && m_t == 2 * L * FIRST + 10) && n < LIMIT) begin
      step(1'b0, 1'b1, 2);
      n++;
    end
    check("wait_active", n < LIMIT, 1'b1);
    repeat (2 * FRAME) step(1'b0, 1'b0, 2);

    // reset in the middle of an active line, then restart
    n = 0;
    while (!(m_busy && m_t == 2 * L * FIRST + 6) && n < LIMIT) begin
      step(1'b0, 1'b1, 2);
      n++;
    end
    check("wait_midline", n < LIMIT, 1'b1);
    step(1'b1, 1'b1, 2);
    repeat (FRAME + 20) step(1'b0, 1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
